seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Cycles through the four digits with a dead time at the start of each slot.
// Digit codes are captured into a snapshot once per frame so a frame never shows a mix of old and new data.
// Optional feature: define SEG_BLINK_EN to enable the blink input (periodic blanking).
module seg_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [15:0] seg_data,
  input  logic [3:0]  dp_en,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Map a code to active-low cathodes {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h2B;
      4'hB:    s = 7'h3F;
      4'hC:    s = 7'h21;
      4'hD:    s = 7'h41;
      4'hE:    s = 7'h0C;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] slot_cnt, slot_nxt;
  logic [1:0]       digit_idx, idx_nxt;
  logic [15:0]      snap_data, snap_data_nxt, cur_data;
  logic [3:0]       snap_dp, snap_dp_nxt, cur_dp;
  logic             running, running_nxt;
  logic [3:0]       code;
  logic             blank;
  logic             blink_gate;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

`ifdef SEG_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Blink half-period counter; phase flips each BLINK_CYCLES while blinking is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink && active) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end else begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end
  end

  // Gate on the live blink input so dropping blink restores the display on the next output update.
  assign blink_gate = blink & blink_phase;
`else
  logic unused_blink;
  assign blink_gate   = 1'b0;
  assign unused_blink = ^{blink, 32'(BLINK_CYCLES)};
`endif

  // Next-state for scan counters and snapshot, plus next output values.
  always_comb begin
    slot_nxt      = slot_cnt;
    idx_nxt       = digit_idx;
    snap_data_nxt = snap_data;
    snap_dp_nxt   = snap_dp;
    running_nxt   = running;
    cur_data      = snap_data;
    cur_dp        = snap_dp;

    if (!active) begin
      slot_nxt      = '0;
      idx_nxt       = 2'd0;
      snap_data_nxt = 16'hFFFF;
      snap_dp_nxt   = 4'h0;
      running_nxt   = 1'b0;
    end else begin
      running_nxt = 1'b1;
      // First active cycle: take a fresh snapshot and use it right away.
      if (!running) begin
        snap_data_nxt = seg_data;
        snap_dp_nxt   = dp_en;
        cur_data      = seg_data;
        cur_dp        = dp_en;
      end
      if (slot_cnt == SLOT_LAST) begin
        slot_nxt = '0;
        idx_nxt  = digit_idx + 2'd1;
        // Frame boundary: next frame shows the data present now.
        if (digit_idx == 2'd3) begin
          snap_data_nxt = seg_data;
          snap_dp_nxt   = dp_en;
        end
      end else begin
        slot_nxt = slot_cnt + CNT_W'(1);
      end
    end

    code  = cur_data[{digit_idx, 2'b00} +: 4];
    blank = !active || (slot_cnt < BLANK_END) || blink_gate;

    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!blank) begin
      an_nxt  = ~(4'b0001 << digit_idx);
      seg_nxt = seg_decode(code);
      dp_nxt  = ~cur_dp[digit_idx];
    end
  end

  // State and output registers; reset blanks the display asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
      snap_data <= 16'hFFFF;
      snap_dp   <= 4'h0;
      running   <= 1'b0;
      an        <= 4'hF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      slot_cnt  <= slot_nxt;
      digit_idx <= idx_nxt;
      snap_data <= snap_data_nxt;
      snap_dp   <= snap_dp_nxt;
      running   <= running_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule
